// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and constants for the memory-access stage.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam int XLEN     = 32;
    localparam int WB_SEL_W = 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Brief    : Selects the addressed byte/half of a read word and extends it.
// Revision : 1.0
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Data-memory handshake, store lane alignment, load extension and
//            the MEM/WB pipeline register, with an ack timeout.
// Revision : 1.0
// ============================================================================
module mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [XLEN-1:0]     i_pc,
    input  logic [XLEN-1:0]     i_alu,
    input  logic [XLEN-1:0]     i_rs2_data,
    input  logic [XLEN-1:0]     i_inst,
    input  logic [WB_SEL_W-1:0] i_wb_sel,
    input  logic                i_regwen,
    input  logic                i_mem_rd,
    input  logic                i_mem_wr,
    output logic                o_stall,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    output logic [XLEN-1:0]     o_dmem_addr,
    output logic [XLEN-1:0]     o_dmem_wdata,
    output logic [3:0]          o_dmem_bmask,
    input  logic                i_dmem_ack,
    input  logic [XLEN-1:0]     i_dmem_rdata,
    output logic [XLEN-1:0]     o_pc,
    output logic [XLEN-1:0]     o_alu,
    output logic [XLEN-1:0]     o_mem,
    output logic [XLEN-1:0]     o_inst,
    output logic [WB_SEL_W-1:0] o_wb_sel,
    output logic                o_regwen,
    output logic                o_valid,
    output logic                o_misalign,
    output logic                o_bus_err
);

    localparam logic [7:0] c_to_last = 8'(ACK_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cnt;
    logic [2:0]      w_f3;
    logic            w_mem_op;
    logic            w_f3_legal;
    logic            w_misalign;
    logic            w_req;
    logic            w_done;
    logic            w_timeout;
    logic            w_stall;
    logic [XLEN-1:0] w_load_data;

    assign w_f3     = i_inst[14:12];
    assign w_mem_op = i_valid & (i_mem_rd | i_mem_wr);

    // Unsupported funct3 encodings are folded into the misaligned path.
    always_comb begin
        if (i_mem_wr)
            w_f3_legal = (w_f3 == F3_SB) | (w_f3 == F3_SH) | (w_f3 == F3_SW);
        else
            w_f3_legal = (w_f3 == F3_LB) | (w_f3 == F3_LH) | (w_f3 == F3_LW)
                       | (w_f3 == F3_LBU) | (w_f3 == F3_LHU);
        w_misalign = w_mem_op & (~w_f3_legal
                   | ((w_f3[1:0] == 2'b01) & i_alu[0])
                   | ((w_f3[1:0] == 2'b10) & (i_alu[1:0] != 2'b00)));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req & ~i_dmem_ack & ~w_timeout) w_next = S_WAIT;
            S_WAIT:  if (w_done | w_timeout)               w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        case (r_state)
            S_IDLE:  w_req = w_mem_op & ~w_misalign;
            S_WAIT:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
        w_req     = w_req & ~i_reset;
        w_done    = w_req & i_dmem_ack;
        w_timeout = w_req & ~i_dmem_ack & (r_cnt == c_to_last);
        w_stall   = w_req & ~i_dmem_ack & ~w_timeout;
    end

    assign o_dmem_req = w_req;
    assign o_dmem_we  = w_req & i_mem_wr;
    assign o_stall    = w_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                 r_cnt <= 8'd0;
        else if (w_done | w_timeout) r_cnt <= 8'd0;
        else if (w_req)              r_cnt <= r_cnt + 8'd1;
    end

    always_comb begin
        o_dmem_addr  = {i_alu[31:2], 2'b00};
        o_dmem_wdata = i_rs2_data;
        o_dmem_bmask = 4'b1111;
        if (i_mem_wr) begin
            case (w_f3[1:0])
                2'b00: begin
                    o_dmem_wdata = {4{i_rs2_data[7:0]}};
                    o_dmem_bmask = 4'b0001 << i_alu[1:0];
                end
                2'b01: begin
                    o_dmem_wdata = {2{i_rs2_data[15:0]}};
                    o_dmem_bmask = i_alu[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    lsu_load_align u_load_align (
        .i_rdata   (i_dmem_rdata),
        .i_addr_lo (i_alu[1:0]),
        .i_funct3  (w_f3),
        .o_data    (w_load_data)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pc       <= '0;
            o_alu      <= '0;
            o_mem      <= '0;
            o_inst     <= NOP_INST;
            o_wb_sel   <= '0;
            o_regwen   <= 1'b0;
            o_valid    <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
        end else if (w_stall) begin
            o_pc       <= '0;
            o_alu      <= '0;
            o_mem      <= '0;
            o_inst     <= NOP_INST;
            o_wb_sel   <= '0;
            o_regwen   <= 1'b0;
            o_valid    <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
        end else begin
            o_pc       <= i_pc;
            o_alu      <= i_alu;
            o_mem      <= (w_done & i_mem_rd) ? w_load_data : '0;
            o_inst     <= i_inst;
            o_wb_sel   <= i_wb_sel;
            o_regwen   <= i_regwen & ~w_misalign & ~w_timeout;
            o_valid    <= i_valid & ~w_misalign & ~w_timeout;
            o_misalign <= w_misalign;
            o_bus_err  <= w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed, scoreboard-checked bench for mem_stage.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_regwen, i_mem_rd, i_mem_wr, i_dmem_ack;
    logic [31:0] i_pc, i_alu, i_rs2_data, i_inst, i_dmem_rdata;
    logic [1:0]  i_wb_sel;
    logic        o_stall, o_dmem_req, o_dmem_we, o_regwen, o_valid, o_misalign, o_bus_err;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_pc, o_alu, o_mem, o_inst;
    logic [3:0]  o_dmem_bmask;
    logic [1:0]  o_wb_sel;

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_pc(i_pc), .i_alu(i_alu),
        .i_rs2_data(i_rs2_data), .i_inst(i_inst), .i_wb_sel(i_wb_sel), .i_regwen(i_regwen),
        .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_bmask(o_dmem_bmask), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_pc(o_pc), .o_alu(o_alu), .o_mem(o_mem), .o_inst(o_inst), .o_wb_sel(o_wb_sel),
        .o_regwen(o_regwen), .o_valid(o_valid), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind: 0 normal retire, 1 misaligned, 2 bus error
    typedef struct {
        logic [31:0] pc, alu, rs2, inst, rdata, addr, wdata, mem;
        logic        rd, wr, regwen, req;
        logic [3:0]  bmask;
        int          ack, kind;
    } vec_t;

    typedef struct {
        logic [31:0] pc, mem;
        logic        regwen;
        int          kind;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mkv(input logic [31:0] pc, alu, rs2, input logic [2:0] f3,
                                 input int op, input logic [31:0] rdata, input int ack,
                                 input logic req, input logic [31:0] addr, wdata,
                                 input logic [3:0] bmask, input logic [31:0] mem, input int kind);
        vec_t v;
        logic [6:0] opc;
        opc = (op == 1) ? 7'b0000011 : (op == 2) ? 7'b0100011 : 7'b0010011;
        v.pc = pc; v.alu = alu; v.rs2 = rs2; v.inst = {17'd0, f3, 5'd5, opc};
        v.rdata = rdata; v.addr = addr; v.wdata = wdata; v.mem = mem;
        v.rd = (op == 1); v.wr = (op == 2); v.regwen = (op != 2); v.req = req;
        v.bmask = bmask; v.ack = ack; v.kind = kind;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && (o_valid || o_misalign || o_bus_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", {o_pc, o_valid, o_misalign, o_bus_err}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.kind == 0)
                    check("retire", {o_pc, o_mem, o_regwen, o_valid, o_misalign, o_bus_err},
                          {e.pc, e.mem, e.regwen, 3'b100});
                else
                    check("retire_fault", {o_regwen, o_valid, o_misalign, o_bus_err},
                          {2'b00, e.kind == 1, e.kind == 2});
            end
        end
    end

    task automatic run(input vec_t v);
        bit   done;
        exp_t e;
        i_valid = 1'b1; i_pc = v.pc; i_alu = v.alu; i_rs2_data = v.rs2; i_inst = v.inst;
        i_regwen = v.regwen; i_mem_rd = v.rd; i_mem_wr = v.wr; i_wb_sel = 2'b01;
        i_dmem_rdata = v.rdata;
        for (int cyc = 1; cyc <= TO + 1; cyc++) begin
            i_dmem_ack = (v.ack == cyc);
            @(negedge clk);
            check("req", o_dmem_req, v.req);
            check("stall", o_stall, v.req && cyc != v.ack && cyc != TO);
            if (v.req) begin
                check("addr_bmask_we", {o_dmem_addr, o_dmem_bmask, o_dmem_we},
                      {v.addr, v.bmask, v.wr});
                if (v.wr) check("wdata", o_dmem_wdata, v.wdata);
            end
            done = !v.req || cyc == v.ack || cyc == TO;
            if (done) begin
                e.pc = v.pc; e.mem = v.mem; e.regwen = v.regwen; e.kind = v.kind;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            if (done) break;
            check("bubble", {o_inst, o_regwen, o_valid}, {NOP_INST, 2'b00});
        end
        i_dmem_ack = 1'b0;
        i_valid    = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        i_valid = 1'b1; i_pc = 32'h0; i_alu = 32'h2000; i_rs2_data = 32'h0;
        i_inst = {17'd0, F3_LW, 5'd5, 7'b0000011}; i_regwen = 1'b1; i_mem_rd = 1'b1;
        i_mem_wr = 1'b0; i_wb_sel = 2'b00; i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_forced", {o_dmem_req, o_stall, o_dmem_we}, 3'b000);
        check("reset_mewb", {o_inst, o_pc, o_mem, o_regwen, o_valid, o_misalign, o_bus_err},
              {NOP_INST, 64'd0, 4'b0000});
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        vecs.push_back(mkv(32'h100, 32'h1001, 32'h0000_00AB, F3_SB, 2, 32'h0, 1, 1'b1,
                           32'h1000, 32'hABAB_ABAB, 4'b0010, 32'h0, 0));
        vecs.push_back(mkv(32'h104, 32'h2001, 32'h0, F3_LB, 1, 32'h80F1_7F22, 1, 1'b1,
                           32'h2000, 32'h0, 4'b1111, 32'h0000_007F, 0));
        vecs.push_back(mkv(32'h108, 32'h2003, 32'h0, F3_LB, 1, 32'h80F1_7F22, 1, 1'b1,
                           32'h2000, 32'h0, 4'b1111, 32'hFFFF_FF80, 0));
        vecs.push_back(mkv(32'h10C, 32'h2002, 32'h0, F3_LHU, 1, 32'h80F1_7F22, 1, 1'b1,
                           32'h2000, 32'h0, 4'b1111, 32'h0000_80F1, 0));
        vecs.push_back(mkv(32'h110, 32'h2002, 32'h0, F3_LH, 1, 32'h80F1_7F22, 1, 1'b1,
                           32'h2000, 32'h0, 4'b1111, 32'hFFFF_80F1, 0));
        vecs.push_back(mkv(32'h114, 32'h2000, 32'h0, F3_LW, 1, 32'h80F1_7F22, 4, 1'b1,
                           32'h2000, 32'h0, 4'b1111, 32'h80F1_7F22, 0));
        vecs.push_back(mkv(32'h118, 32'h0000_0055, 32'h0, 3'b000, 0, 32'h0, 0, 1'b0,
                           32'h0, 32'h0, 4'b0, 32'h0, 0));
        vecs.push_back(mkv(32'h11C, 32'h2002, 32'h0, F3_LW, 1, 32'h0, 0, 1'b0,
                           32'h0, 32'h0, 4'b0, 32'h0, 1));
        vecs.push_back(mkv(32'h120, 32'h1001, 32'h0, F3_SH, 2, 32'h0, 0, 1'b0,
                           32'h0, 32'h0, 4'b0, 32'h0, 1));
        vecs.push_back(mkv(32'h124, 32'h2000, 32'h0, 3'b011, 1, 32'h0, 0, 1'b0,
                           32'h0, 32'h0, 4'b0, 32'h0, 1));
        vecs.push_back(mkv(32'h128, 32'h1002, 32'h1234_BEEF, F3_SH, 2, 32'h0, 2, 1'b1,
                           32'h1000, 32'hBEEF_BEEF, 4'b1100, 32'h0, 0));
        vecs.push_back(mkv(32'h12C, 32'h3000, 32'h0, F3_LW, 1, 32'h0, 0, 1'b1,
                           32'h3000, 32'h0, 4'b1111, 32'h0, 2));
        vecs.push_back(mkv(32'h130, 32'h3000, 32'h0, F3_LW, 1, 32'hCAFE_F00D, 4, 1'b1,
                           32'h3000, 32'h0, 4'b1111, 32'hCAFE_F00D, 0));
        vecs.push_back(mkv(32'h134, 32'h1004, 32'hDEAD_BEEF, F3_SW, 2, 32'h0, 1, 1'b1,
                           32'h1004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 0));

        foreach (vecs[i]) run(vecs[i]);

        // Stalled load interrupted by reset on its second request cycle.
        i_valid = 1'b1; i_pc = 32'h200; i_alu = 32'h2000; i_inst = {17'd0, F3_LW, 5'd5, 7'b0000011};
        i_regwen = 1'b1; i_mem_rd = 1'b1; i_mem_wr = 1'b0; i_dmem_ack = 1'b0;
        @(negedge clk);
        check("rst_pre_stall", {o_dmem_req, o_stall}, 2'b11);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_drop_req", {o_dmem_req, o_stall}, 2'b00);
        check("rst_mewb", {o_inst, o_valid, o_regwen}, {NOP_INST, 2'b00});
        check("rst_state", dut.r_state, S_IDLE);
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run(vecs[1]);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
